// File: rtl/div_ctrl_if.sv
// Handshake bundle between the EX stage and the multi-cycle divider.
// The pipeline side uses the master modport; the divider uses slave.
interface div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic                 signed_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 stallreq_o;

    modport master (
        output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
        input  result_o, ready_o, stallreq_o
    );

    modport slave (
        input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
        output result_o, ready_o, stallreq_o
    );
endinterface

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer: latches operand magnitudes, runs WIDTH restoring
// steps, applies the sign fix on the last step and holds {rem, quo} until EX drops start.
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    div_ctrl_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [PW-1:0]        part_q, part_d;
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic                 quo_neg_q, quo_neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH+1:0]     step_top, step_diff;
    logic [PW-1:0]        step_part;
    logic [WIDTH-1:0]     quo_raw, rem_raw, quo_fix, rem_fix;

    assign abs_a = (bus.signed_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
    assign abs_b = (bus.signed_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

    // One restoring step: shift partial remainder left, subtract divisor if it fits.
    assign step_top  = part_q[PW-1:WIDTH-1];
    assign step_diff = step_top - {2'b00, divisor_q};
    assign step_part = step_diff[WIDTH+1] ? {part_q[PW-2:0], 1'b0}
                                          : {step_diff[WIDTH:0], part_q[WIDTH-2:0], 1'b1};

    assign quo_raw = step_part[WIDTH-1:0];
    assign rem_raw = step_part[2*WIDTH-1:WIDTH];
    assign quo_fix = quo_neg_q ? -quo_raw : quo_raw;
    assign rem_fix = rem_neg_q ? -rem_raw : rem_raw;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        part_d    = part_q;
        divisor_d = divisor_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;

        if (bus.annul_i) begin
            state_d  = IDLE;
            cnt_d    = '0;
            result_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        divisor_d = abs_b;
                        part_d    = {{(WIDTH+1){1'b0}}, abs_a};
                        quo_neg_d = bus.signed_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
                        rem_neg_d = bus.signed_i & bus.opdata1_i[WIDTH-1];
                        cnt_d     = '0;
                        state_d   = (bus.opdata2_i == '0) ? BYZERO : ON;
                    end
                end
                BYZERO: begin
                    state_d  = END;
                    result_d = '0;
                end
                ON: begin
                    part_d = step_part;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d  = END;
                        result_d = {rem_fix, quo_fix};
                    end
                end
                END: begin
                    if (!bus.start_i) begin
                        state_d  = IDLE;
                        result_d = '0;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    result_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            part_q    <= '0;
            divisor_q <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            part_q    <= part_d;
            divisor_q <= divisor_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
        end
    end

    // Reset gating keeps the stall request quiet while the sequencer is held in reset.
    assign bus.stallreq_o = rst_n & bus.start_i & ~bus.annul_i & (state_q != END);
    assign bus.ready_o    = (state_q == END);
    assign bus.result_o   = result_q;
endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: a latency/arithmetic model checked every cycle,
// plus literal expectations for the documented divide cases.
module tb_div_ctrl;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    div_ctrl_if #(.WIDTH(W)) bus ();

    div_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: truncating division, remainder takes the dividend's sign.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Transaction-level model: busy for a fixed number of edges, then done until start drops.
    logic        m_busy, m_done;
    int          m_left;
    logic [63:0] m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
            m_res  <= 64'd0;
        end else if (bus.annul_i) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
        end else if (m_done) begin
            if (!bus.start_i) m_done <= 1'b0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
            end
        end else if (bus.start_i) begin
            m_busy <= 1'b1;
            m_left <= (bus.opdata2_i == 32'd0) ? 1 : W;
            m_res  <= ref_div(bus.signed_i, bus.opdata1_i, bus.opdata2_i);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_ready", 64'(bus.ready_o), 64'(m_done));
            chk("cyc_result", bus.result_o, m_done ? m_res : 64'd0);
            chk("cyc_stall", 64'(bus.stallreq_o),
                64'(rst_n & bus.start_i & ~bus.annul_i & ~m_done));
        end
    end

    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int exp_edges, input int hold,
                           input bit scramble);
        int edges;
        int stalls;
        edges  = 0;
        stalls = 0;
        @(posedge clk); #1;
        bus.start_i   = 1'b1;
        bus.signed_i  = s;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        #1;
        if (bus.stallreq_o) stalls++;
        while (edges < 200) begin
            @(posedge clk); #1;
            edges++;
            if (bus.ready_o) break;
            if (bus.stallreq_o) stalls++;
            if (scramble && edges == 5) begin
                bus.opdata1_i = $urandom;
                bus.opdata2_i = $urandom;
                bus.signed_i  = ~s;
            end
        end
        $display("div s=%0d a=%h b=%h -> result=%h edges=%0d stalls=%0d",
                 s, a, b, bus.result_o, edges, stalls);
        chk("latency", 64'(edges), 64'(exp_edges));
        chk("stall_cycles", 64'(stalls), 64'(exp_edges));
        chk("result", bus.result_o, exp);
        chk("stall_when_ready", 64'(bus.stallreq_o), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_ready", 64'(bus.ready_o), 64'd1);
            chk("hold_result", bus.result_o, exp);
        end
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        chk("drop_ready", 64'(bus.ready_o), 64'd0);
        chk("drop_result", bus.result_o, 64'd0);
    endtask

    initial begin
        bus.start_i   = 1'b0;
        bus.signed_i  = 1'b0;
        bus.opdata1_i = '0;
        bus.opdata2_i = '0;
        bus.annul_i   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 64'(bus.ready_o), 64'd0);
        chk("reset_result", bus.result_o, 64'd0);
        chk("reset_stall", 64'(bus.stallreq_o), 64'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0, 1'b1);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0, 1'b0);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33, 0, 1'b0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33, 0, 1'b0);
        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, 33, 0, 1'b0);
        run_div(1'b1, 32'd5, 32'd0, 64'd0, 2, 5, 1'b0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33, 2, 1'b0);
        run_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14}, 33, 0, 1'b0);

        // Flush mid-divide, then a fresh divide must be unaffected.
        @(posedge clk); #1;
        bus.start_i   = 1'b1;
        bus.signed_i  = 1'b0;
        bus.opdata1_i = 32'd1000;
        bus.opdata2_i = 32'd7;
        repeat (11) @(posedge clk);
        #1;
        bus.annul_i = 1'b1;
        #1;
        chk("annul_stall", 64'(bus.stallreq_o), 64'd0);
        @(posedge clk); #1;
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        chk("annul_ready", 64'(bus.ready_o), 64'd0);
        chk("annul_result", bus.result_o, 64'd0);
        $display("annul applied mid-divide, ready=%0d", bus.ready_o);
        run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 0, 1'b0);

        // Asynchronous reset between edges, mid-divide and while a result is held.
        @(posedge clk); #1;
        bus.start_i   = 1'b1;
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        repeat (12) @(posedge clk);
        #2;
        rst_n       = 1'b0;
        bus.start_i = 1'b0;
        #1;
        chk("arst_on_ready", 64'(bus.ready_o), 64'd0);
        chk("arst_on_stall", 64'(bus.stallreq_o), 64'd0);
        chk("arst_on_result", bus.result_o, 64'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        $display("async reset mid-divide released");

        @(posedge clk); #1;
        bus.start_i   = 1'b1;
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        repeat (34) @(posedge clk);
        #1;
        chk("pre_arst_result", bus.result_o, {32'd2, 32'd14});
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_end_ready", 64'(bus.ready_o), 64'd0);
        chk("arst_end_result", bus.result_o, 64'd0);
        chk("arst_end_stall", 64'(bus.stallreq_o), 64'd0);
        bus.start_i = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        $display("async reset while result held released");

        run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0, 1'b0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
